// File: rtl/adc_fifo_drain_if.sv
// adc_fifo_drain_if: FIFO read-side and host block-pipe signals of the ADC drain controller.
// master = drain controller, slave = FIFO/host side.
interface adc_fifo_drain_if #(
    parameter int DATA_W = 256,
    parameter int CNT_W  = 7
);
    logic              fifo_rd_en;
    logic              fifo_valid;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_rd_data_cnt;
    logic [DATA_W-1:0] fifo_data;
    logic              host_ready;
    logic              host_strobe;
    logic [DATA_W-1:0] host_data;

    modport master (
        output fifo_rd_en, host_strobe, host_data,
        input  fifo_valid, fifo_empty, fifo_full,
        input  fifo_rd_data_cnt, fifo_data, host_ready
    );

    modport slave (
        input  fifo_rd_en, host_strobe, host_data,
        output fifo_valid, fifo_empty, fifo_full,
        output fifo_rd_data_cnt, fifo_data, host_ready
    );
endinterface

// File: rtl/adc_fifo_drain_ctrl.sv
// adc_fifo_drain_ctrl: burst read scheduler from the ADC pixel FIFO to the host pipe.
// Optional DRAIN_FLUSH_EN adds a FLUSH state that discards leftover FIFO words.
module adc_fifo_drain_ctrl #(
    parameter int DATA_W    = 256,
    parameter int CNT_W     = 7,
    parameter int BURST_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    adc_fifo_drain_if.master bus,
    output logic             busy,
    output logic             burst_done,
    output logic [15:0]      burst_cnt,
    input  logic             ovf_clr,
    output logic             overflow
`ifdef DRAIN_FLUSH_EN
    ,
    input  logic             flush,
    output logic [CNT_W-1:0] flush_words
`endif
);

    localparam logic [CNT_W-1:0] LEN    = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
`ifdef DRAIN_FLUSH_EN
        ,
        S_FLUSH
`endif
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] issued, recv;
    logic             rd_en, start, done, in_burst;

    assign in_burst       = (state == S_ISSUE) || (state == S_WAIT);
    assign busy           = (state != S_IDLE);
    assign bus.fifo_rd_en = rd_en & ~rst;

    // Next-state and read-enable decode; a burst only starts with a whole burst buffered.
    always_comb begin
        state_n = state;
        rd_en   = 1'b0;
        start   = 1'b0;
        done    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable && bus.host_ready && bus.fifo_rd_data_cnt >= LEN) begin
                    state_n = S_ISSUE;
                    start   = 1'b1;
                end
`ifdef DRAIN_FLUSH_EN
                else if (!enable && flush) begin
                    state_n = S_FLUSH;
                end
`endif
            end
            S_ISSUE: begin
                rd_en = ~bus.fifo_empty;
                if (rd_en && issued == LEN_M1) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (recv == LEN) begin
                    state_n = S_IDLE;
                    done    = 1'b1;
                end
            end
`ifdef DRAIN_FLUSH_EN
            S_FLUSH: begin
                rd_en = ~bus.fifo_empty;
                if (bus.fifo_empty && !bus.fifo_valid) state_n = S_IDLE;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Issued-read and received-word counters, restarted at each burst start.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            issued <= '0;
            recv   <= '0;
        end else begin
            if (state == S_ISSUE && rd_en) issued <= issued + 1'b1;
            if (in_burst && bus.fifo_valid) recv <= recv + 1'b1;
        end
    end

    // Host datapath: words returned outside a burst are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.host_strobe <= 1'b0;
            bus.host_data   <= '0;
        end else begin
            bus.host_strobe <= in_burst & bus.fifo_valid;
            if (in_burst && bus.fifo_valid) bus.host_data <= bus.fifo_data;
        end
    end

    // Burst completion pulse and wrapping burst counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_done <= 1'b0;
            burst_cnt  <= '0;
        end else begin
            burst_done <= done;
            if (done) burst_cnt <= burst_cnt + 16'd1;
        end
    end

    // Sticky overflow; a new full event beats a coincident clear.
    always_ff @(posedge clk) begin
        if (rst)                        overflow <= 1'b0;
        else if (bus.fifo_full && enable) overflow <= 1'b1;
        else if (ovf_clr)               overflow <= 1'b0;
    end

`ifdef DRAIN_FLUSH_EN
    // Count words discarded by the current flush.
    always_ff @(posedge clk) begin
        if (rst)                                      flush_words <= '0;
        else if (state == S_IDLE && state_n == S_FLUSH) flush_words <= '0;
        else if (state == S_FLUSH && bus.fifo_valid)  flush_words <= flush_words + 1'b1;
    end
`endif

endmodule

// File: tb/tb_adc_fifo_drain_ctrl.sv
// tb_adc_fifo_drain_ctrl: directed checks of adc_fifo_drain_ctrl against a small FIFO model.
// Define DRAIN_FLUSH_EN to also exercise the flush path.
module tb_adc_fifo_drain_ctrl;
    localparam int DATA_W = 256;
    localparam int CNT_W  = 7;
    localparam int BL     = 16;

    typedef logic [DATA_W-1:0] word_t;

    logic        clk = 1'b0;
    logic        rst, enable, ovf_clr;
    logic        busy, burst_done, overflow;
    logic [15:0] burst_cnt;
`ifdef DRAIN_FLUSH_EN
    logic             flush;
    logic [CNT_W-1:0] flush_words;
`endif

    always #5 clk = ~clk;

    adc_fifo_drain_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    adc_fifo_drain_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bus        (bus),
        .busy       (busy),
        .burst_done (burst_done),
        .burst_cnt  (burst_cnt),
        .ovf_clr    (ovf_clr),
        .overflow   (overflow)
`ifdef DRAIN_FLUSH_EN
        ,
        .flush      (flush),
        .flush_words(flush_words)
`endif
    );

    // FIFO model: pointers into a word store, one-cycle read latency.
    word_t mem [0:255];
    int    wr_ptr = 0;
    int    rd_ptr = 0;
    logic  force_empty = 1'b0;
    logic  full = 1'b0;

    assign bus.fifo_rd_data_cnt = CNT_W'(wr_ptr - rd_ptr);
    assign bus.fifo_empty       = (wr_ptr == rd_ptr) || force_empty;
    assign bus.fifo_full        = full;

    always @(posedge clk) begin
        bus.fifo_valid <= 1'b0;
        if (bus.fifo_rd_en) begin
            bus.fifo_data  <= mem[rd_ptr[7:0]];
            bus.fifo_valid <= 1'b1;
            rd_ptr         <= rd_ptr + 1;
        end
    end

    function automatic word_t word(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {8{w}};
    endfunction

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[7:0]] = word(wr_ptr);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    // Monitor: log read enables, strobes and done pulses by cycle.
    int    cyc = 0;
    int    rd_q[$];
    int    st_q[$];
    word_t rx_q[$];
    int    done_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.fifo_rd_en) rd_q.push_back(cyc);
        if (bus.host_strobe) begin
            st_q.push_back(cyc);
            rx_q.push_back(bus.host_data);
        end
        if (burst_done) done_n <= done_n + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input word_t got, input word_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag, output int drops);
        int n;
        n     = 0;
        drops = 0;
        while (!burst_done && n < 200) begin
            @(negedge clk);
            n++;
            if (!burst_done && !busy) drops++;
        end
        chk({tag, "_done_seen"}, word_t'(burst_done), word_t'(1));
        #2;
    endtask

    task automatic check_data(input string tag, input int st0, input int first);
        int bad;
        bad = 0;
        for (int i = 0; i < BL; i++) begin
            if (st0 + i >= rx_q.size()) bad++;
            else if (rx_q[st0 + i] !== word(first + i)) bad++;
        end
        chk({tag, "_order"}, word_t'(bad), word_t'(0));
    endtask

    int rd0, st0, d0, first, drops, n;

    initial begin
        rst            = 1'b1;
        enable         = 1'b0;
        ovf_clr        = 1'b0;
        bus.host_ready = 1'b0;
`ifdef DRAIN_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", word_t'(busy), word_t'(0));
        chk("rst_rden", word_t'(bus.fifo_rd_en), word_t'(0));
        chk("rst_strobe", word_t'(bus.host_strobe), word_t'(0));
        chk("rst_cnt", word_t'(burst_cnt), word_t'(0));
        chk("rst_ovf", word_t'(overflow), word_t'(0));
        @(negedge clk);
        rst = 1'b0;

        // 1) full burst, latency and contiguity
        rd0 = rd_q.size(); st0 = st_q.size(); d0 = done_n; first = wr_ptr;
        push(BL);
        bus.host_ready = 1'b1;
        enable         = 1'b1;
        wait_done("t1", drops);
        chk("t1_reads", word_t'(rd_q.size() - rd0), word_t'(BL));
        chk("t1_strobes", word_t'(st_q.size() - st0), word_t'(BL));
        if (st_q.size() >= st0 + BL && rd_q.size() > rd0) begin
            chk("t1_latency", word_t'(st_q[st0] - rd_q[rd0]), word_t'(2));
            chk("t1_contig", word_t'(st_q[st0 + BL - 1] - st_q[st0]), word_t'(BL - 1));
        end
        check_data("t1", st0, first);
        chk("t1_burst_cnt", word_t'(burst_cnt), word_t'(1));
        chk("t1_busy_held", word_t'(drops), word_t'(0));
        @(negedge clk);
        #1;
        chk("t1_done_pulse", word_t'(burst_done), word_t'(0));
        chk("t1_done_n", word_t'(done_n - d0), word_t'(1));

        // 2) one word short holds off; the 16th word starts it
        rd0 = rd_q.size(); st0 = st_q.size(); first = wr_ptr;
        push(BL - 1);
        repeat (4) @(negedge clk);
        #1;
        chk("t2_no_start", word_t'(rd_q.size() - rd0), word_t'(0));
        chk("t2_idle", word_t'(busy), word_t'(0));
        @(negedge clk);
        push(1);
        @(negedge clk);
        #1;
        chk("t2_start", word_t'(bus.fifo_rd_en), word_t'(1));
        wait_done("t2", drops);
        chk("t2_strobes", word_t'(st_q.size() - st0), word_t'(BL));
        check_data("t2", st0, first);
        chk("t2_burst_cnt", word_t'(burst_cnt), word_t'(2));

        // 3) empty stall mid-burst, enable/host_ready dropped mid-burst
        @(negedge clk);
        rd0 = rd_q.size(); st0 = st_q.size(); first = wr_ptr;
        push(BL);
        repeat (4) @(negedge clk);
        enable         = 1'b0;
        bus.host_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            force_empty = 1'b1;
            #1;
            chk("t3_stall_rden", word_t'(bus.fifo_rd_en), word_t'(0));
            chk("t3_stall_busy", word_t'(busy), word_t'(1));
            @(negedge clk);
        end
        force_empty = 1'b0;
        wait_done("t3", drops);
        chk("t3_reads", word_t'(rd_q.size() - rd0), word_t'(BL));
        chk("t3_strobes", word_t'(st_q.size() - st0), word_t'(BL));
        check_data("t3", st0, first);
        chk("t3_burst_cnt", word_t'(burst_cnt), word_t'(3));
        chk("t3_busy_held", word_t'(drops), word_t'(0));

`ifdef DRAIN_FLUSH_EN
        // 6) flush of a partial burst
        @(negedge clk);
        rd0 = rd_q.size(); st0 = st_q.size();
        push(5);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 50);
        #2;
        chk("t6_idle", word_t'(busy), word_t'(0));
        chk("t6_reads", word_t'(rd_q.size() - rd0), word_t'(5));
        chk("t6_strobes", word_t'(st_q.size() - st0), word_t'(0));
        chk("t6_words", word_t'(flush_words), word_t'(5));
`endif

        // 4) reset after the eighth word
        @(negedge clk);
        st0 = st_q.size();
        push(BL);
        enable         = 1'b1;
        bus.host_ready = 1'b1;
        n = 0;
        while (st_q.size() - st0 < 8 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t4_reached8", word_t'(st_q.size() - st0), word_t'(8));
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t4_strobe", word_t'(bus.host_strobe), word_t'(0));
        chk("t4_rden", word_t'(bus.fifo_rd_en), word_t'(0));
        chk("t4_busy", word_t'(busy), word_t'(0));
        chk("t4_cnt", word_t'(burst_cnt), word_t'(0));
        chk("t4_data", bus.host_data, word_t'(0));
        rst    = 1'b0;
        enable = 1'b0;
        st0    = st_q.size();
        repeat (5) @(negedge clk);
        #1;
        chk("t4_no_strobe", word_t'(st_q.size() - st0), word_t'(0));
        chk("t4_done", word_t'(burst_done), word_t'(0));

        // 5) sticky overflow
        @(negedge clk);
        enable = 1'b1;
        full   = 1'b1;
        @(negedge clk);
        full = 1'b0;
        #1;
        chk("t5_set", word_t'(overflow), word_t'(1));
        @(negedge clk);
        #1;
        chk("t5_sticky", word_t'(overflow), word_t'(1));
        ovf_clr = 1'b1;
        full    = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        full    = 1'b0;
        #1;
        chk("t5_set_wins", word_t'(overflow), word_t'(1));
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        #1;
        chk("t5_clear", word_t'(overflow), word_t'(0));
        enable = 1'b0;
        full   = 1'b1;
        @(negedge clk);
        full = 1'b0;
        #1;
        chk("t5_gated", word_t'(overflow), word_t'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
